// File: rtl/uart_cfg_pkg.sv
// Shared constants and types for the configuration UART link (receiver and readback).
package uart_cfg_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int unsigned CFG_WIDTH_DEF = 52;

    // Configuration vector is zero-padded at the MSB end to whole bytes.
    function automatic int unsigned cfg_bytes(input int unsigned width);
        return (width + 7) / 8;
    endfunction

    localparam int unsigned CFG_BYTES   = cfg_bytes(CFG_WIDTH_DEF);
    // Sync byte + config bytes + status byte + checksum byte.
    localparam int unsigned FRAME_BYTES = CFG_BYTES + 3;

    // Status byte field positions: {6'b0, config_error, config_done}.
    localparam int unsigned STATUS_DONE_BIT  = 0;
    localparam int unsigned STATUS_ERROR_BIT = 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } bit_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serialiser: baud counter, shifter and bit FSM.
// 8N1 by default; define UART_TX_PARITY_EN for 8E1 (even parity before stop).
// ready_o is also high in the final stop-bit cycle so the next byte can be
// loaded with no gap on the line.
module uart_tx_byte
    import uart_cfg_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       byte_done_o,
    output logic       tx_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    bit_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic bit_end;

    // Decode handshake strobes from the bit FSM state.
    always_comb begin
        bit_end     = (cnt_q == DIV_LAST);
        byte_done_o = (state_q == StStop) && bit_end;
        ready_o     = (state_q == StIdle) || byte_done_o;
        tx_o        = tx_q;
    end

    // Bit FSM: each line bit is held for DIV cycles; tx is registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (load_i) begin
                        state_q   <= StStart;
                        tx_q      <= 1'b0;
                        shift_q   <= data_i;
                        bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^data_i;
`endif
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (load_i) begin
                            state_q   <= StStart;
                            tx_q      <= 1'b0;
                            shift_q   <= data_i;
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            parity_q  <= ^data_i;
`endif
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_config_readback.sv
// Configuration readback transmitter: on start_i, snapshots the config vector
// and receiver status and sends sync, config bytes, status and XOR checksum.
// Optional macro UART_TX_PARITY_EN selects 8E1 framing in uart_tx_byte.
module uart_config_readback
    import uart_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 11_059_200,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned CFG_WIDTH = 52
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CFG_WIDTH-1:0] config_bits_i,
    input  logic                 config_done_i,
    input  logic                 config_error_i,
    output logic                 uart_tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned DIV             = CLK_FREQ / BAUD_RATE;
    localparam int unsigned NUM_CFG_BYTES   = cfg_bytes(CFG_WIDTH);
    localparam int unsigned NUM_FRAME_BYTES = NUM_CFG_BYTES + 3;
    localparam int unsigned IW              = $clog2(NUM_FRAME_BYTES);
    localparam logic [IW-1:0] LAST_IDX      = IW'(NUM_FRAME_BYTES - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_config_readback: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    logic                       busy_q;
    logic                       done_q;
    logic [IW-1:0]              idx_q;
    logic [CFG_WIDTH-1:0]       cfg_q;
    logic [7:0]                 status_q;
    logic [7:0]                 csum_q;

    logic                       tx_ready;
    logic                       tx_byte_done;
    logic                       tx_load;
    logic [7:0]                 tx_byte;
    logic                       accept;
    logic                       advance;
    logic                       frame_last;
    logic [NUM_CFG_BYTES*8-1:0] cfg_pad;
    int unsigned                next_num;
    logic [7:0]                 next_byte;
    logic                       next_in_csum;

    // Pick the byte that follows idx_q, and whether it feeds the checksum.
    always_comb begin
        cfg_pad                = '0;
        cfg_pad[CFG_WIDTH-1:0] = cfg_q;
        next_num               = 32'(idx_q) + 32'd1;
        next_byte              = csum_q;
        next_in_csum           = 1'b0;
        if (next_num <= NUM_CFG_BYTES) begin
            next_byte    = cfg_pad[8*(next_num-1) +: 8];
            next_in_csum = 1'b1;
        end else if (next_num == NUM_CFG_BYTES + 1) begin
            next_byte    = status_q;
            next_in_csum = 1'b1;
        end
    end

    // Frame sequencing strobes and the byte handed to the serialiser.
    always_comb begin
        accept     = start_i && !busy_q && tx_ready;
        frame_last = busy_q && tx_byte_done && (idx_q == LAST_IDX);
        advance    = busy_q && tx_byte_done && (idx_q != LAST_IDX);
        tx_load    = accept || advance;
        tx_byte    = accept ? SYNC_BYTE : next_byte;
    end

    // Frame-level state: snapshot on accept, byte index, checksum, done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            cfg_q    <= '0;
            status_q <= '0;
            csum_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q                     <= 1'b1;
                idx_q                      <= '0;
                csum_q                     <= '0;
                cfg_q                      <= config_bits_i;
                status_q                   <= '0;
                status_q[STATUS_DONE_BIT]  <= config_done_i;
                status_q[STATUS_ERROR_BIT] <= config_error_i;
            end else if (frame_last) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                idx_q  <= '0;
            end else if (advance) begin
                idx_q <= idx_q + 1'b1;
                if (next_in_csum) begin
                    csum_q <= csum_q ^ next_byte;
                end
            end
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx_byte (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (tx_load),
        .data_i      (tx_byte),
        .ready_o     (tx_ready),
        .byte_done_o (tx_byte_done),
        .tx_o        (uart_tx_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_config_readback.sv
// Bench for uart_config_readback with DIV=16; honours UART_TX_PARITY_EN.
module tb_uart_config_readback;

    localparam int DIV = 16;
    localparam int FB  = 10;
`ifdef UART_TX_PARITY_EN
    localparam int BPB = 11;
`else
    localparam int BPB = 10;
`endif
    localparam int FC = FB * BPB * DIV;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [51:0] config_bits_i;
    logic        config_done_i;
    logic        config_error_i;
    logic        uart_tx_o;
    logic        busy_o;
    logic        done_o;

    int tests;
    int fails;

    logic [7:0] exp_bytes [FB];
    logic [7:0] dec [FB];

    typedef struct {
        logic [51:0] cfg;
        logic        d;
        logic        e;
        logic [7:0]  b7;
        logic [7:0]  st;
        logic [7:0]  cs;
    } vec_t;

    vec_t vecs [4];

    uart_config_readback #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1),
        .CFG_WIDTH (52)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .config_bits_i  (config_bits_i),
        .config_done_i  (config_done_i),
        .config_error_i (config_error_i),
        .uart_tx_o      (uart_tx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [51:0] rand52();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[51:0];
    endfunction

    // Reference frame: sync, config bytes LSB first, status, XOR checksum.
    function automatic void model_frame(input logic [51:0] cfg, input logic d, input logic e);
        logic [7:0] cs;
        cs = 8'h00;
        exp_bytes[0] = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            exp_bytes[i+1] = 8'((cfg >> (8 * i)) & 52'hFF);
            cs = cs ^ exp_bytes[i+1];
        end
        exp_bytes[8] = 8'(d) + 8'(2 * e);
        cs = cs ^ exp_bytes[8];
        exp_bytes[9] = cs;
    endfunction

    // Expected line level k cycles after the frame's first start-bit cycle.
    function automatic logic exp_line(input int k);
        int b;
        int bp;
        b  = k / (BPB * DIV);
        bp = (k / DIV) % BPB;
        if (bp == 0) return 1'b0;
        if (bp <= 8) return exp_bytes[b][bp-1];
        if (bp == 9 && BPB == 11) return ^exp_bytes[b];
        return 1'b1;
    endfunction

    // Called at a sample point; request is accepted on the next edge.
    task automatic start_frame(input logic [51:0] cfg, input logic d, input logic e,
                               input bit hold);
        config_bits_i  = cfg;
        config_done_i  = d;
        config_error_i = e;
        start_i        = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    // Entered at the first frame cycle (T+1); leaves at the done_o cycle.
    task automatic watch_frame(input logic [51:0] cfg, input logic d, input logic e,
                               input bit disturb, input int abort_at);
        int bad;
        int bp;
        bad = 0;
        model_frame(cfg, d, e);
        for (int i = 0; i < FB; i++) dec[i] = 8'h00;
        for (int k = 0; k < FC; k++) begin
            if (uart_tx_o !== exp_line(k) || busy_o !== 1'b1 || done_o !== 1'b0) bad++;
            if (k % DIV == DIV / 2) begin
                bp = (k / DIV) % BPB;
                if (bp >= 1 && bp <= 8) dec[k / (BPB * DIV)][bp-1] = uart_tx_o;
            end
            if (disturb && k == 300) begin
                config_bits_i  = rand52();
                config_done_i  = ~d;
                config_error_i = ~e;
                start_i        = 1'b1;
            end
            if (disturb && k == 340) start_i = 1'b0;
            if (k == abort_at) begin
                check("frame_wave_pre_abort_bad_cycles", 64'(bad), 64'd0);
                rst_i = 1'b1;
                @(posedge clk);
                #1;
                rst_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("frame_wave_bad_cycles", 64'(bad), 64'd0);
        check("done_pulse_{done,busy,tx}", {61'd0, done_o, busy_o, uart_tx_o}, 64'b101);
    endtask

    task automatic after_done();
        @(posedge clk);
        #1;
        check("done_single_{done,busy,tx}", {61'd0, done_o, busy_o, uart_tx_o}, 64'b001);
    endtask

    task automatic idle_check(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [51:0] cfg;
        logic        d;
        logic        e;

        tests = 0;
        fails = 0;

        vecs[0] = '{cfg: 52'h0,              d: 1'b1, e: 1'b0, b7: 8'h00, st: 8'h01, cs: 8'h01};
        vecs[1] = '{cfg: 52'hF_FFFF_FFFF_FFFF, d: 1'b1, e: 1'b0, b7: 8'h0F, st: 8'h01, cs: 8'h0E};
        vecs[2] = '{cfg: 52'h1_2345_6789_ABCD, d: 1'b0, e: 1'b1, b7: 8'h01, st: 8'h02, cs: 8'hED};
        vecs[3] = '{cfg: 52'hA_5A5A_5A5A_5A5A, d: 1'b1, e: 1'b1, b7: 8'h0A, st: 8'h03, cs: 8'h09};

        rst_i          = 1'b1;
        start_i        = 1'b0;
        config_bits_i  = '0;
        config_done_i  = 1'b0;
        config_error_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 64'(uart_tx_o), 64'd1);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;
        idle_check("idle_100_bad_cycles", 100);

        // Table-driven frames with known byte contents.
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].cfg, vecs[v].d, vecs[v].e, 1'b0);
            watch_frame(vecs[v].cfg, vecs[v].d, vecs[v].e, 1'b0, -1);
            check($sformatf("vec%0d_sync", v), 64'(dec[0]), 64'hA5);
            check($sformatf("vec%0d_cfg_byte6", v), 64'(dec[7]), 64'(vecs[v].b7));
            check($sformatf("vec%0d_status", v), 64'(dec[8]), 64'(vecs[v].st));
            check($sformatf("vec%0d_checksum", v), 64'(dec[9]), 64'(vecs[v].cs));
            after_done();
        end

        // Inputs change and start is re-pulsed mid-frame: snapshot holds, no queueing.
        cfg = rand52();
        start_frame(cfg, 1'b1, 1'b0, 1'b0);
        watch_frame(cfg, 1'b1, 1'b0, 1'b1, -1);
        after_done();
        idle_check("no_second_frame_bad_cycles", 60);

        // Reset at frame cycle 700, then a fresh frame.
        cfg = rand52();
        start_frame(cfg, 1'b0, 1'b1, 1'b0);
        watch_frame(cfg, 1'b0, 1'b1, 1'b0, 700);
        check("abort_{tx,busy,done}", {61'd0, uart_tx_o, busy_o, done_o}, 64'b100);
        idle_check("abort_no_done_bad_cycles", 1000);
        cfg = rand52();
        start_frame(cfg, 1'b1, 1'b1, 1'b0);
        watch_frame(cfg, 1'b1, 1'b1, 1'b0, -1);
        after_done();

        // start_i held high: back-to-back frames with one idle cycle between.
        cfg = rand52();
        d   = 1'($urandom_range(0, 1));
        e   = 1'($urandom_range(0, 1));
        start_frame(cfg, d, e, 1'b1);
        for (int f = 0; f < 3; f++) begin
            watch_frame(cfg, d, e, 1'b0, -1);
            if (f < 2) begin
                cfg            = rand52();
                d              = 1'($urandom_range(0, 1));
                e              = 1'($urandom_range(0, 1));
                config_bits_i  = cfg;
                config_done_i  = d;
                config_error_i = e;
                @(posedge clk);
                #1;
            end
        end
        start_i = 1'b0;
        after_done();

        // Randomised frames against the reference model.
        for (int r = 0; r < 6; r++) begin
            cfg = rand52();
            d   = 1'($urandom_range(0, 1));
            e   = 1'($urandom_range(0, 1));
            start_frame(cfg, d, e, 1'b0);
            watch_frame(cfg, d, e, 1'b0, -1);
            check($sformatf("rand%0d_checksum", r), 64'(dec[9]), 64'(exp_bytes[9]));
            after_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_config_readback.md
Name: uart_config_readback

Overview:
- UART transmitter for the FPGA configuration path; the return channel of the configuration UART receiver.
- On request, it serialises a snapshot of the 52-bit fabric configuration vector plus receiver status, so host tooling can verify what was loaded.
- Sits in the FPGA top beside the configuration receiver, shares its clock and baud settings, and drives one output pad.

Parameters:
- CLK_FREQ, 11_059_200, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. DIV = CLK_FREQ/BAUD_RATE (integer division). Elaboration fails if DIV < 2.
- CFG_WIDTH, 52, configuration vector width. Padded with zeros at the MSB end to CFG_BYTES = ceil(CFG_WIDTH/8) = 7 bytes.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset; one clock; reset is synchronous and active-high.
- start_i  input  1  readback request, sampled every cycle.
- config_bits_i  input  CFG_WIDTH  configuration vector to report.
- config_done_i  input  1  receiver "configuration complete" flag.
- config_error_i  input  1  receiver error flag.
- uart_tx_o  output  1  serial line, idle high.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: uart_tx_o=1, busy_o=0, done_o=0. FSM returns to IDLE, all counters are cleared.
- Frame, in order: sync byte 0xA5, then config bytes 0..CFG_BYTES-1 (byte 0 = bits [7:0]), then status byte {6'b0, config_error, config_done}, then checksum = XOR of all config and status bytes (sync excluded). Total 10 bytes with the defaults.
- Byte format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1. Each bit is held exactly DIV cycles.
- Request accept:
  - start_i=1 while busy_o=0 is accepted in cycle T.
  - config_bits_i, config_done_i and config_error_i are snapshotted in T. Later input changes do not affect the frame.
  - In cycle T+1: busy_o=1 and uart_tx_o=0 (first start bit).
- start_i while busy_o=1 is ignored; no queueing.
- FSM states: IDLE -> START (DIV cycles) -> DATA (8×DIV cycles) -> STOP (DIV cycles). After STOP:
  - next byte pending: go to START;
  - last byte sent: go to IDLE.
- Byte index counter 0..9 and bit counter 0..7 both wrap to 0 on frame end.
- Frame end:
  - The cycle after the last stop-bit cycle, done_o=1 for exactly one cycle and busy_o=0.
  - Frame length with defaults = 100×DIV cycles from T+1.
- start_i high in the done_o cycle is accepted (busy_o already 0), giving back-to-back frames with one idle cycle on the line.
- Reset mid-frame: the frame is aborted, uart_tx_o=1 in the next cycle, and no done_o pulse is emitted.
- Checksum is accumulated byte-by-byte as bytes load into the shifter. Width is 8 bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data and stop (8E1). Each byte takes 11×DIV cycles; default frame = 110×DIV cycles.
- Undefined: 8N1, no parity state, no parity logic.

Decomposition:
- Package uart_cfg_pkg holds: SYNC_BYTE=8'hA5, FRAME_BYTES = CFG_BYTES+3, the bit-level state enum (IDLE, START, DATA, PARITY, STOP), and status byte field positions. The receiver shares these constants.
- Sub-module uart_tx_byte contains the baud counter, the shifter and the bit FSM. Handshake:
  - inputs: load strobe + byte;
  - outputs: ready, byte_done pulse, tx line.
- Top level sequences frame bytes and computes the checksum.

Test Plan (sim with CLK_FREQ=16, BAUD_RATE=1, so DIV=16):
- Reset then idle 100 cycles -> uart_tx_o=1, busy_o=0, done_o=0 throughout.
- config_bits_i=0, done=1, error=0, start pulse -> bytes A5, 00×7, 01, checksum 01. done_o pulses 1600 cycles after busy rises; each bit is 16 cycles wide.
- config_bits_i=52'hF_FFFF_FFFF_FFFF, done=1 -> bytes A5, FF×6, 0F, 01, checksum 0E.
- Change config_bits_i and pulse start_i again mid-frame -> frame content unchanged, no second frame, a single done_o.
- Assert rst_i at cycle 700 of a frame -> uart_tx_o=1 the next cycle, busy_o=0, no done_o; a new start afterwards yields a correct full frame.
- start_i held high continuously -> back-to-back frames separated by exactly one idle-high cycle. With UART_TX_PARITY_EN: frame = 1760 cycles, parity bit of 0xA5 = 0.
